bram_test_ctrl: RTL and testbench
=================================

Name: bram_test_ctrl

Overview:
- Self-test sequencer that sits directly upstream of the 4096x4 banked BRAM block and drives its we/addr/din inputs.
- On start it fills all 4096 addresses with a deterministic address-derived pattern, clears the memory's registered per-bank write enables, then reads every address back and compares against the expected value.
- Reports pass/fail, an error count and the first failing address to the board-level status logic.

Parameters:
- ADDR_W, 12, memory address width; depth = 2**ADDR_W.
- DATA_W, 4, memory data width.
- READ_LAT, 3, cycles from mem_addr driven to matching mem_dout valid; legal range 1..8.
- WR_DATA_LAG, 1, cycles mem_din lags mem_addr/mem_we; legal values 0 or 1.
- SEED, 4'h5, pattern seed.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle start pulse.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  DATA_W  write data to memory.
- mem_dout  in  DATA_W  read data from memory.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  high from test completion until the next accepted start.
- pass  out  1  valid while done; 1 = zero errors.
- err_count  out  13  mismatch count, saturating at 8191.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset: all outputs 0, state IDLE, internal pipelines cleared. Reset asserted mid-test aborts immediately; no resume.
- Pattern: P(a) = a[3:0] ^ a[11:8] ^ SEED.
- States: IDLE, WRITE, FLUSH, READ, DRAIN, DONE.
- IDLE/DONE + start: clear err_count and first_err_addr, drop done, go to WRITE. start is ignored in WRITE, FLUSH, READ and DRAIN.
- WRITE:
  - mem_we=1; mem_addr counts 0..4095, one per cycle.
  - mem_din = P(addr) delayed by WR_DATA_LAG cycles.
  - After addr 4095, go to FLUSH.
- FLUSH: 4 cycles with mem_we=0, mem_addr = 0, 1024, 2048, 3072 in turn. This deasserts every bank's registered write enable. Then go to READ.
- READ:
  - mem_we=0; mem_addr counts 0..4095.
  - Each issued address pushes {valid, addr, P(addr)} into a READ_LAT-deep shift pipeline.
  - When a valid entry exits, compare it with mem_dout. On mismatch, increment err_count (saturating). If this is the first error, latch first_err_addr.
- DRAIN: READ_LAT cycles with no new reads, letting the pipeline empty. Then go to DONE.
- DONE:
  - done=1, busy=0, pass=(err_count==0); mem_we=0, mem_addr=0.
  - A start arriving in the same cycle as entry into DONE is ignored.
- Total busy duration: 4096+4+4096+READ_LAT cycles (8199 at default).
- Counters wrap from 4095 to 0 only on phase exit; no other wrap-around.

Optional Feature:
- BRAM_TEST_INV_PASS_EN
  - Defined: after the first DRAIN, run a second WRITE/FLUSH/READ/DRAIN pass using ~P(a). Errors accumulate across both passes; busy duration doubles (16398 at default).
  - Undefined: single true-pattern pass only; no extra state logic.

Test Plan:
- Ideal memory model (READ_LAT=3, din lag 1), start pulse at cycle 10 -> busy for 8199 cycles, then done=1, pass=1, err_count=0, first_err_addr=0.
- Model corrupts the read at addr 0x123 (returns ~P) -> err_count=1, first_err_addr=0x123, pass=0.
- mem_dout[2] stuck at 0 -> err_count=2048, first_err_addr=0x000 (P(0)=5 has bit 2 set), pass=0.
- start pulsed again at cycle 3000 and cycle 5000 during the run -> ignored; done timing unchanged. start after done -> counters cleared, new run completes identically.
- reset asserted at cycle 2000 mid-WRITE -> all outputs 0 that same cycle, state IDLE; a fresh start runs to pass=1.
- With BRAM_TEST_INV_PASS_EN and an ideal model -> busy 16398 cycles, pass=1. With bit 0 stuck at 1 -> err_count=4096 (2048 per pass).

Source files
------------

// File: rtl/bram_test_ctrl.sv
// bram_test_ctrl: self-test sequencer for the 4096x4 banked BRAM.
// Fills memory with an address-derived pattern, flushes the banks'
// registered write enables, reads everything back and reports the result.
// Optional feature macro: BRAM_TEST_INV_PASS_EN adds a second pass that uses
// the inverted pattern; errors accumulate across both passes.
module bram_test_ctrl #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 4,
    parameter int                READ_LAT    = 3,
    parameter int                WR_DATA_LAG = 1,
    parameter logic [DATA_W-1:0] SEED        = 4'h5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [12:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [ADDR_W-1:0] CNT_LAST   = '1;
    localparam logic [ADDR_W-1:0] FLUSH_LAST = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(READ_LAT - 1);
    localparam logic [12:0]       ERR_MAX    = '1;

    // Pattern is built from the low and high nibbles of the address only.
    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] lo,
                                                  input logic [DATA_W-1:0] hi);
        return lo ^ hi ^ SEED;
    endfunction

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [DATA_W-1:0] pat_mask;
    logic [DATA_W-1:0] cur_pattern;
    logic [DATA_W-1:0] din_next;
    logic              last_pass;
    logic              start_ok;
    logic              mismatch;

    assign start_ok    = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign cur_pattern = pattern(cnt_reg[DATA_W-1:0], cnt_reg[ADDR_W-1 -: DATA_W]) ^ pat_mask;

`ifdef BRAM_TEST_INV_PASS_EN
    logic inv_reg;

    // Track which pass is running; the inverted pass follows the first drain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inv_reg <= 1'b0;
        end else if (start_ok) begin
            inv_reg <= 1'b0;
        end else if (state_reg == ST_DRAIN && cnt_reg == DRAIN_LAST) begin
            inv_reg <= 1'b1;
        end
    end

    assign pat_mask  = {DATA_W{inv_reg}};
    assign last_pass = inv_reg;
`else
    assign pat_mask  = '0;
    assign last_pass = 1'b1;
`endif

    // Phase sequencing; cnt_reg is the per-phase address/cycle counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_WRITE;
                        cnt_reg   <= '0;
                    end
                end
                ST_WRITE: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_reg == FLUSH_LAST) begin
                        state_reg <= ST_READ;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_READ: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_reg == DRAIN_LAST) begin
                        state_reg <= last_pass ? ST_DONE : ST_WRITE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Memory address: counter in WRITE/READ, one address per bank in FLUSH.
    always_comb begin
        mem_addr = '0;
        case (state_reg)
            ST_WRITE, ST_READ: mem_addr = cnt_reg;
            ST_FLUSH:          mem_addr = {cnt_reg[1:0], {(ADDR_W-2){1'b0}}};
            default:           mem_addr = '0;
        endcase
    end

    assign mem_we = (state_reg == ST_WRITE);
    assign busy   = (state_reg == ST_WRITE) || (state_reg == ST_FLUSH) ||
                    (state_reg == ST_READ)  || (state_reg == ST_DRAIN);
    assign done   = (state_reg == ST_DONE);
    assign pass   = done && (err_count == '0);

    assign din_next = (state_reg == ST_WRITE) ? cur_pattern : '0;

    // Write data either accompanies the address or trails it by one cycle.
    if (WR_DATA_LAG == 0) begin : g_din_now
        assign mem_din = din_next;
    end else begin : g_din_lag
        logic [DATA_W-1:0] din_reg;

        // One-cycle data lag behind address/we.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                din_reg <= '0;
            end else begin
                din_reg <= din_next;
            end
        end

        assign mem_din = din_reg;
    end

    // Expected-value pipeline aligned to the memory read latency.
    logic              pv_reg [READ_LAT];
    logic [ADDR_W-1:0] pa_reg [READ_LAT];
    logic [DATA_W-1:0] pe_reg [READ_LAT];

    for (genvar gi = 0; gi < READ_LAT; gi++) begin : g_pipe
        if (gi == 0) begin : g_head
            // Capture each issued read with its expected data.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_reg[0] <= 1'b0;
                    pa_reg[0] <= '0;
                    pe_reg[0] <= '0;
                end else begin
                    pv_reg[0] <= (state_reg == ST_READ);
                    pa_reg[0] <= cnt_reg;
                    pe_reg[0] <= cur_pattern;
                end
            end
        end else begin : g_tail
            // Shift the entry one stage closer to the compare point.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pv_reg[gi] <= 1'b0;
                    pa_reg[gi] <= '0;
                    pe_reg[gi] <= '0;
                end else begin
                    pv_reg[gi] <= pv_reg[gi-1];
                    pa_reg[gi] <= pa_reg[gi-1];
                    pe_reg[gi] <= pe_reg[gi-1];
                end
            end
        end
    end

    assign mismatch = pv_reg[READ_LAT-1] && (pe_reg[READ_LAT-1] != mem_dout);

    // Error accounting: saturating count plus address of the first failure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (start_ok) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (mismatch) begin
            if (err_count != ERR_MAX) begin
                err_count <= err_count + 13'd1;
            end
            if (err_count == '0) begin
                first_err_addr <= pa_reg[READ_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_bram_test_ctrl.sv
// tb_bram_test_ctrl: directed bench for bram_test_ctrl with a behavioural
// BRAM model (registered write enable, 3-cycle read) and fault injection.
`timescale 1ns/1ps
module tb_bram_test_ctrl;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 4;
    localparam int READ_LAT = 3;
`ifdef BRAM_TEST_INV_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BUSY_CYCLES = PASSES * (4096 + 4 + 4096 + READ_LAT);
    localparam int LIMIT       = BUSY_CYCLES + 100;

    localparam int F_NONE    = 0;
    localparam int F_CORRUPT = 1;
    localparam int F_B2_LOW  = 2;
    localparam int F_B0_HIGH = 3;

    typedef struct {
        int   cycles;
        int   errs;
        int   first;
        logic pass;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              busy;
    logic              done;
    logic              pass;
    logic [12:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    int   checks = 0;
    int   errors = 0;
    int   fault_mode = F_NONE;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bram_test_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // Memory model: write enable/address registered, data taken one cycle later.
    logic [DATA_W-1:0] mem [4096];
    logic              we_d = 1'b0;
    logic [ADDR_W-1:0] addr_d = '0;
    logic [DATA_W-1:0] rd_pipe [READ_LAT];
    logic [ADDR_W-1:0] ra_pipe [READ_LAT];
    logic [DATA_W-1:0] dout_raw;

    always @(posedge clk) begin
        we_d   <= mem_we;
        addr_d <= mem_addr;
        if (we_d) mem[addr_d] <= mem_din;
        rd_pipe[0] <= mem[mem_addr];
        ra_pipe[0] <= mem_addr;
        for (int i = 1; i < READ_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            ra_pipe[i] <= ra_pipe[i-1];
        end
    end

    always_comb begin
        dout_raw = rd_pipe[READ_LAT-1];
        case (fault_mode)
            F_CORRUPT: if (ra_pipe[READ_LAT-1] == 12'h123) dout_raw = ~dout_raw;
            F_B2_LOW:  dout_raw[2] = 1'b0;
            F_B0_HIGH: dout_raw[0] = 1'b1;
            default:   dout_raw = rd_pipe[READ_LAT-1];
        endcase
        mem_dout = dout_raw;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: count readback differences over every address of every pass.
    task automatic ref_model(input int fm, output int errs, output int first);
        logic [11:0] aa;
        logic [3:0]  e;
        logic [3:0]  d;
        errs  = 0;
        first = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < 4096; a++) begin
                aa = a[11:0];
                e  = aa[3:0] ^ aa[11:8] ^ 4'h5;
                if (p == 1) e = ~e;
                d = e;
                if (fm == F_CORRUPT && aa == 12'h123) d = ~d;
                if (fm == F_B2_LOW)  d[2] = 1'b0;
                if (fm == F_B0_HIGH) d[0] = 1'b1;
                if (d != e) begin
                    if (errs == 0) first = a;
                    errs++;
                end
            end
        end
    endtask

    task automatic run_test(input int fm, input bit poke, input string name);
        exp_t e;
        exp_t got;
        int   errs;
        int   first;
        int   cyc;
        fault_mode = fm;
        ref_model(fm, errs, first);
        e.cycles = BUSY_CYCLES;
        e.errs   = errs;
        e.first  = first;
        e.pass   = (errs == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sb_q.push_back(e);
        check({name, ":busy_on"},  32'(busy), 32'd1);
        check({name, ":done_off"}, 32'(done), 32'd0);
        check({name, ":err_clr"},  32'(err_count), 32'd0);
        cyc = 0;
        while (busy === 1'b1 && cyc < LIMIT) begin
            cyc++;
            start = poke && (cyc == 3000 || cyc == 5000 || cyc == BUSY_CYCLES);
            @(negedge clk);
        end
        start = 1'b0;
        got = sb_q.pop_front();
        $display("run %s: busy=%0d err=%0d first=0x%0h pass=%0d", name, cyc, err_count,
                 first_err_addr, pass);
        check({name, ":busy_cycles"}, 32'(cyc), 32'(got.cycles));
        check({name, ":done"},        32'(done), 32'd1);
        check({name, ":pass"},        32'(pass), 32'(got.pass));
        check({name, ":err_count"},   32'(err_count), 32'(got.errs));
        check({name, ":first_err"},   32'(first_err_addr), 32'(got.first));
        if (poke) begin
            @(negedge clk);
            check({name, ":done_hold"}, 32'(done), 32'd1);
            check({name, ":busy_hold"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst:mem_we",   32'(mem_we), 32'd0);
        check("rst:mem_addr", 32'(mem_addr), 32'd0);
        check("rst:busy",     32'(busy), 32'd0);
        check("rst:done",     32'(done), 32'd0);
        check("rst:pass",     32'(pass), 32'd0);
        reset = 1'b0;
        repeat (6) @(negedge clk);

        run_test(F_CORRUPT, 1'b0, "corrupt123");
        run_test(F_NONE, 1'b1, "ideal_poke");
`ifdef BRAM_TEST_INV_PASS_EN
        run_test(F_B0_HIGH, 1'b0, "bit0_high");
`else
        run_test(F_B2_LOW, 1'b0, "bit2_low");
`endif

        // Abort mid-WRITE with reset, then make sure nothing resumes.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (1999) @(negedge clk);
        check("mid:we_before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        check("mid:mem_we",   32'(mem_we), 32'd0);
        check("mid:mem_addr", 32'(mem_addr), 32'd0);
        check("mid:mem_din",  32'(mem_din), 32'd0);
        check("mid:busy",     32'(busy), 32'd0);
        check("mid:done",     32'(done), 32'd0);
        check("mid:err",      32'(err_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("mid:idle_busy", 32'(busy), 32'd0);
        check("mid:idle_we",   32'(mem_we), 32'd0);
        check("mid:idle_done", 32'(done), 32'd0);

        run_test(F_NONE, 1'b0, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
